// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes used by decode and both ALU generations,
// plus the state encoding of the multi-cycle ALU controller.
package alu_pkg;

  localparam logic [3:0] FN_AND   = 4'b0000;
  localparam logic [3:0] FN_OR    = 4'b0001;
  localparam logic [3:0] FN_XOR   = 4'b0010;
  localparam logic [3:0] FN_XNOR  = 4'b0011;
  localparam logic [3:0] FN_ADD   = 4'b0100;
  localparam logic [3:0] FN_SLT   = 4'b0101;
  localparam logic [3:0] FN_SLL   = 4'b0110;
  localparam logic [3:0] FN_SRL   = 4'b0111;
  localparam logic [3:0] FN_MUL   = 4'b1000;
  localparam logic [3:0] FN_MULHU = 4'b1001;
  localparam logic [3:0] FN_DIVU  = 4'b1010;
  localparam logic [3:0] FN_REMU  = 4'b1011;
  localparam logic [3:0] FN_SUB   = 4'b1100;
  localparam logic [3:0] FN_SLTU  = 4'b1101;
  localparam logic [3:0] FN_SRA   = 4'b1110;
  localparam logic [3:0] FN_RSVD  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide,
// one step per cycle while run is high; done flags the final step.
module alu_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             run,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH:0]     rem_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic [1:0]         op_reg;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH+1:0]   rem_shift;
  logic [WIDTH+1:0]   rem_diff;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next;

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  // Divide: acc low half shifts the dividend out and the quotient in.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    mul_next  = {mul_sum, acc_reg[WIDTH-1:1]};
    rem_shift = {rem_reg, acc_reg[WIDTH-1]};
    rem_diff  = rem_shift - {2'b00, opnd_reg};
    if (!rem_diff[WIDTH+1]) begin
      rem_next = rem_diff[WIDTH:0];
      quo_next = {acc_reg[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_shift[WIDTH:0];
      quo_next = {acc_reg[WIDTH-2:0], 1'b0};
    end
    case (op_reg)
      2'b00:   result = mul_next[WIDTH-1:0];
      2'b01:   result = mul_next[2*WIDTH-1:WIDTH];
      2'b10:   result = quo_next;
      default: result = rem_next[WIDTH-1:0];
    endcase
  end

  // The counter reaches WIDTH on the same edge that retires the final step.
  assign done = run && (cnt_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      acc_reg  <= '0;
      rem_reg  <= '0;
      opnd_reg <= '0;
      op_reg   <= '0;
    end else if (start) begin
      cnt_reg  <= '0;
      op_reg   <= op;
      rem_reg  <= '0;
      acc_reg  <= {{WIDTH{1'b0}}, (op[1] ? a : b)};
      opnd_reg <= op[1] ? b : a;
    end else if (run) begin
      cnt_reg <= cnt_reg + 1'b1;
      if (op_reg[1]) begin
        acc_reg <= {{WIDTH{1'b0}}, quo_next};
        rem_reg <= rem_next;
      end else begin
        acc_reg <= mul_next;
      end
    end
  end

endmodule

// File: rtl/alu_mc_unit.sv
// Registered multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative
// multiply/divide, behind valid/ready handshakes on both sides.
module alu_mc_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [3:0]       Func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUout,
  output logic             busy
);

  localparam int SH_W = $clog2(WIDTH);

  alu_state_t       state_reg, state_next;
  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] md_result;
  logic             md_done;
  logic             accept;
  logic             is_md;
  logic [SH_W-1:0]  sh_amt;

  assign sh_amt = In2[SH_W-1:0];
  assign is_md  = (Func[3:2] == 2'b10);
  assign accept = in_valid && in_ready;

  always_comb begin
    single_res = '0;
    case (Func)
      FN_AND:  single_res = In1 & In2;
      FN_OR:   single_res = In1 | In2;
      FN_XOR:  single_res = In1 ^ In2;
      FN_XNOR: single_res = ~(In1 ^ In2);
      FN_ADD:  single_res = In1 + In2;
      FN_SUB:  single_res = In1 - In2;
      FN_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(In1) < $signed(In2))};
      FN_SLTU: single_res = {{(WIDTH-1){1'b0}}, (In1 < In2)};
      FN_SLL:  single_res = In1 << sh_amt;
      FN_SRL:  single_res = In1 >> sh_amt;
      FN_SRA:  single_res = $signed(In1) >>> sh_amt;
      default: single_res = '0;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && is_md),
    .run    (state_reg == ST_BUSY),
    .op     (Func[1:0]),
    .a      (In1),
    .b      (In2),
    .done   (md_done),
    .result (md_result)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = is_md ? ST_BUSY : ST_DONE;
      ST_BUSY: if (md_done) state_next = ST_DONE;
      ST_DONE: begin
        if (accept)         state_next = is_md ? ST_BUSY : ST_DONE;
        else if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept && !is_md) out_reg <= single_res;
      else if (md_done)     out_reg <= md_result;
    end
  end

  // A held result blocks new work until the consumer takes it.
  assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg == ST_BUSY);
  assign ALUout    = out_reg;

endmodule

// File: tb/tb_alu_mc_unit.sv
// Bench for alu_mc_unit: timeline/result model with per-cycle compare, plus
// directed vectors with hand-computed results and latencies.
module tb_alu_mc_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] In1 = '0;
  logic [W-1:0] In2 = '0;
  logic [3:0]   Func = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] ALUout;

  always #5 clk = ~clk;

  alu_mc_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .In1       (In1),
    .In2       (In2),
    .Func      (Func),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUout    (ALUout),
    .busy      (busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sh;
    sh = int'(b[4:0]);
    p  = {32'b0, a} * {32'b0, b};
    case (f)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a ^ b;
      4'b0011: return ~(a ^ b);
      4'b0100: return a + b;
      4'b1100: return a - b;
      4'b0101: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1101: return (a < b) ? 32'd1 : 32'd0;
      4'b0110: return a << sh;
      4'b0111: return a >> sh;
      4'b1110: return $signed(a) >>> sh;
      4'b1000: return p[31:0];
      4'b1001: return p[63:32];
      4'b1010: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'b1011: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Outstanding operation: expected result and the cycle it becomes visible.
  typedef struct {
    logic [31:0] res;
    int          rdy;
    bit          md;
  } item_t;
  item_t q[$];
  int cyc = 0;

  always @(posedge clk) begin
    bit    ov, ir;
    item_t it;
    if (rst) begin
      q.delete();
    end else begin
      ov = (q.size() > 0) && (cyc >= q[0].rdy);
      ir = (q.size() == 0) || (ov && out_ready);
      if (ov && out_ready) void'(q.pop_front());
      if (in_valid && ir) begin
        it.res = model(Func, In1, In2);
        it.md  = (Func[3:2] == 2'b10);
        it.rdy = cyc + (it.md ? W + 1 : 1);
        q.push_back(it);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit ov, ir, bz;
    if (rst) begin
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_ALUout", ALUout, 32'd0);
    end else begin
      ov = (q.size() > 0) && (cyc >= q[0].rdy);
      bz = (q.size() > 0) && q[0].md && (cyc < q[0].rdy);
      ir = (q.size() == 0) || (ov && out_ready);
      check("mon_out_valid", {31'b0, out_valid}, {31'b0, ov});
      check("mon_busy", {31'b0, busy}, {31'b0, bz});
      check("mon_in_ready", {31'b0, in_ready}, {31'b0, ir});
      if (ov) check("mon_ALUout", ALUout, q[0].res);
    end
  end

  // Called at #1 after a rising edge with in_valid low and out_ready high.
  task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input string nm);
    bit acc, got;
    int lat, busy_n, rdy_n;
    in_valid = 1'b1; Func = f; In1 = a; In2 = b;
    acc = 0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    In1 = $urandom; In2 = $urandom; Func = 4'($urandom);
    if (!acc) check({nm, "_accept_timeout"}, 32'd0, 32'd1);
    lat = 0; busy_n = 0; rdy_n = 0; got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (in_ready) rdy_n++;
      if (out_valid) begin
        got = 1;
        check(nm, ALUout, exp);
      end
    end
    if (!got) check({nm, "_result_timeout"}, 32'd0, 32'd1);
    check({nm, "_latency"}, lat, exp_lat);
    check({nm, "_busy_cycles"}, busy_n, exp_lat - 1);
    check({nm, "_in_ready_cycles"}, rdy_n, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);

    check("model_add", model(4'b0100, 32'd5, 32'd11), 32'd16);
    check("model_xnor", model(4'b0011, 32'd5, 32'd11), 32'hFFFF_FFF1);
    check("model_mulhu", model(4'b1001, 32'h0001_0000, 32'h0001_0000), 32'd1);
    check("model_remu0", model(4'b1011, 32'd9, 32'd0), 32'd9);

    // Back-to-back ADD then XNOR
    @(posedge clk); #1;
    in_valid = 1'b1; Func = 4'b0100; In1 = 32'd5; In2 = 32'd11;
    @(posedge clk); #1;
    Func = 4'b0011;
    @(negedge clk);
    check("t1_add_valid", {31'b0, out_valid}, 32'd1);
    check("t1_add", ALUout, 32'd16);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_xnor_valid", {31'b0, out_valid}, 32'd1);
    check("t1_xnor", ALUout, 32'hFFFF_FFF1);
    @(posedge clk); #1;

    run_op(4'b1100, 32'd5, 32'd11, 32'hFFFF_FFFA, 1, "t2_sub");
    run_op(4'b0101, 32'hFFFF_FFFA, 32'd1, 32'd1, 1, "t2_slt");
    run_op(4'b1101, 32'hFFFF_FFFA, 32'd1, 32'd0, 1, "t2_sltu");
    run_op(4'b1110, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, "t2_sra");
    run_op(4'b0110, 32'd1, 32'd31, 32'h8000_0000, 1, "t2_sll31");
    run_op(4'b0111, 32'h8000_0000, 32'd36, 32'h0800_0000, 1, "t2_srl_wrap");
    run_op(4'b1111, 32'd123, 32'd456, 32'd0, 1, "t2_reserved");

    run_op(4'b1000, 32'h0001_0000, 32'h0001_0000, 32'd0, W + 1, "t3_mul");
    run_op(4'b1001, 32'h0001_0000, 32'h0001_0000, 32'd1, W + 1, "t3_mulhu");
    run_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, W + 1, "t3_mul_max");

    run_op(4'b1010, 32'd100, 32'd7, 32'd14, W + 1, "t4_divu");
    run_op(4'b1011, 32'd100, 32'd7, 32'd2, W + 1, "t4_remu");
    run_op(4'b1010, 32'd9, 32'd0, 32'hFFFF_FFFF, W + 1, "t4_divu_zero");
    run_op(4'b1011, 32'd9, 32'd0, 32'd9, W + 1, "t4_remu_zero");

    // Output held while the consumer stalls; pending op waits for out_ready
    out_ready = 1'b0;
    in_valid = 1'b1; Func = 4'b0100; In1 = 32'd7; In2 = 32'd8;
    @(posedge clk); #1;
    Func = 4'b1100; In1 = 32'd20; In2 = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_valid", {31'b0, out_valid}, 32'd1);
      check("t5_hold_value", ALUout, 32'd15);
      check("t5_hold_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t5_release_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("t5_sub", ALUout, 32'd17);
    @(posedge clk); #1;

    // Reset in the middle of a divide
    in_valid = 1'b1; Func = 4'b1010; In1 = 32'd1000; In2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("t6_rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(4'b0001, 32'd5, 32'd10, 32'd15, 1, "t6_or");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mc_unit.md
Name: alu_mc_unit

Overview:
- Parametrised, registered successor to the single-cycle ALU.
- Executes the existing logic/add/sub/SLT function set in 1 cycle.
- Adds shifts, unsigned compare, and iterative multiply/divide (WIDTH cycles).
- Sits in the EX stage behind a valid/ready handshake so the pipeline stalls on long ops instead of needing a combinational result.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  In1/In2/Func valid this cycle.
- in_ready  output  1  unit can accept an operation this cycle.
- In1  input  WIDTH  operand A.
- In2  input  WIDTH  operand B.
- Func  input  4  operation code.
- out_valid  output  1  ALUout holds a completed result.
- out_ready  input  1  consumer takes result this cycle.
- ALUout  output  WIDTH  registered result.
- busy  output  1  multi-cycle op in progress.

Behaviour:
- Func encoding, with WIDTH-bit wrap-around arithmetic:
  - 0000 AND; 0001 OR; 0010 XOR; 0011 XNOR.
  - 0100 ADD; 1100 SUB (In1-In2).
  - 0101 SLT: signed, result 0 or 1.
  - 1101 SLTU: unsigned, result 0 or 1.
  - 0110 SLL; 0111 SRL; 1110 SRA, each by In2[$clog2(WIDTH)-1:0].
  - 1000 MUL: low WIDTH bits of the unsigned product.
  - 1001 MULHU: high WIDTH bits of the unsigned product.
  - 1010 DIVU: unsigned quotient.
  - 1011 REMU: unsigned remainder.
  - 1111: reserved; produces 0 with single-cycle latency.
- FSM states:
  - IDLE -> DONE on accept of a single-cycle op.
  - IDLE -> BUSY on accept of a 10xx op.
  - BUSY -> DONE when the iteration counter reaches WIDTH.
  - DONE -> IDLE on out_ready with no new accept.
  - DONE -> DONE or BUSY on out_ready with a simultaneous accept.
- Accept rule: accept happens when in_valid && in_ready. in_ready = (state==IDLE) || (state==DONE && out_ready).
- Operand capture: inputs are captured only at accept. Later changes to In1/In2/Func have no effect.
- Latency, accept at edge N:
  - Single-cycle op: out_valid=1 after edge N+1.
  - MUL/MULHU/DIVU/REMU: out_valid=1 after edge N+WIDTH+1. busy=1 for exactly WIDTH cycles.
- Multiply: shift-add, one partial product per cycle into a 2*WIDTH accumulator.
- Divide: restoring, one quotient bit per cycle. The remainder register is WIDTH+1 bits.
- Divide by zero, with no exception flag:
  - DIVU returns all-ones.
  - REMU returns In1.
  - Both still take WIDTH+1 cycles.
- Output hold: ALUout and out_valid stay stable while out_valid && !out_ready. No result is dropped or overwritten.
- Back-to-back single-cycle ops with out_ready held high give one result per cycle.
- Reset values: state=IDLE, out_valid=0, busy=0, ALUout=0, counter=0, accumulators=0. in_ready reads 1 once reset deasserts.
- Reset mid-operation: in-flight result discarded immediately (async). No spurious out_valid after release.
- in_valid while in_ready=0: ignored. The producer must hold it.

Decomposition:
- Shared package alu_pkg holds:
  - Func localparams (FN_AND ... FN_REMU) shared with decode and the existing ALU.
  - FSM state encoding.
- One sub-module, alu_muldiv_iter: iterative multiply/divide datapath with start/done, counter and accumulators.
- Top level holds the combinational single-cycle ops, FSM, handshake and output register.

Test Plan (WIDTH=32):
1. Reset, then ADD In1=5 In2=11 with out_ready=1 -> out_valid one cycle after accept, ALUout=16. Follow with XNOR on the same operands -> 0xFFFFFFF1, back-to-back.
2. SUB 5-11 -> 0xFFFFFFFA. SLT 0xFFFFFFFA vs 1 -> 1. SLTU on the same operands -> 0. SRA 0x80000000 by 4 -> 0xF8000000.
3. MUL 0x10000 x 0x10000 -> 0, and MULHU -> 0x1. busy high exactly 32 cycles, out_valid at cycle 33 after accept, in_ready=0 throughout.
4. DIVU 100/7 -> 14, REMU -> 2. DIVU 9/0 -> 0xFFFFFFFF, REMU 9/0 -> 9.
5. out_ready=0 for 5 cycles after an ADD result -> ALUout and out_valid held. A new in_valid stays unaccepted until out_ready=1, then is accepted in the same cycle.
6. Assert rst at cycle 10 of a DIVU -> out_valid=0, busy=0 immediately. A subsequent OR 5|10 -> 15.
